// File: rtl/newton_div_pipe.sv
// newton_div_pipe
//   Iterative Newton-Raphson fractional divider, q = a / b.
//   A 16-entry seed ROM gives x0 ~ 1/b, ITER refinements x <- x*(2 - b*x)
//   follow, then a final q = a*x with sticky LSB and saturation.
//
// Ports
//   clk        clock
//   rst        synchronous reset, active-high
//   in_valid   operands valid
//   in_ready   block idle and able to accept operands
//   a          dividend, fraction 0.WIDTH
//   b          divisor, fraction 0.WIDTH, normalised (b[WIDTH-1]=1)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   q          quotient, format 1.(WIDTH-1)
//   err        divisor was unnormalised or zero (qualified by out_valid)
//   busy       operation in progress (complement of in_ready)
module newton_div_pipe #(
  parameter int WIDTH = 24,
  parameter int ITER  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             err,
  output logic             busy
);

  localparam int XW = WIDTH + 2;      // x and e, format 2.WIDTH
  localparam int PW = 2 * WIDTH + 2;  // a*x, format 2.(2*WIDTH)
  localparam logic [2:0]    LAST_CNT = 3'(ITER - 1);
  localparam logic [XW-1:0] ONE_X    = {2'b01, {WIDTH{1'b0}}};
  localparam logic [XW-1:0] TWO_X    = {2'b10, {WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED  = 3'd1,
    S_MUL_B = 3'd2,
    S_MUL_X = 3'd3,
    S_FINAL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Reciprocal seed fraction for b in [0.5 + idx/32, 0.5 + (idx+1)/32).
  function automatic logic [7:0] seed_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    seed_rom = 8'hff;
      4'd1:    seed_rom = 8'hdf;
      4'd2:    seed_rom = 8'hc3;
      4'd3:    seed_rom = 8'haa;
      4'd4:    seed_rom = 8'h93;
      4'd5:    seed_rom = 8'h7f;
      4'd6:    seed_rom = 8'h6d;
      4'd7:    seed_rom = 8'h5c;
      4'd8:    seed_rom = 8'h4d;
      4'd9:    seed_rom = 8'h3f;
      4'd10:   seed_rom = 8'h33;
      4'd11:   seed_rom = 8'h27;
      4'd12:   seed_rom = 8'h1c;
      4'd13:   seed_rom = 8'h12;
      4'd14:   seed_rom = 8'h08;
      4'd15:   seed_rom = 8'h00;
      default: seed_rom = 8'h00;
    endcase
  endfunction

  state_t           state_r, state_n;
  logic [WIDTH-1:0] a_r, b_r, q_r;
  logic [XW-1:0]    x_r, e_r;
  logic [2:0]       cnt_r;
  logic             err_r, out_valid_r, in_ready_r, busy_r;

  logic [PW-1:0]    ax_full_s;
  logic [XW-1:0]    x_seed_s, bx_s, e_next_s, x_next_s;
  logic [WIDTH-1:0] q_final_s;
  logic             sticky_s, out_fire_s;

  // x0 = 1 + rom/256, ROM value placed in the top eight fraction bits.
  assign x_seed_s = ONE_X | ({{(XW-8){1'b0}}, seed_rom(b_r[WIDTH-2:WIDTH-5])} << (WIDTH-8));

  // b*x realigned from 2.(2*WIDTH) to 2.WIDTH (truncated), then e = 2.0 - b*x.
  assign bx_s     = XW'(({{XW{1'b0}}, b_r} * {{WIDTH{1'b0}}, x_r}) >> WIDTH);
  assign e_next_s = TWO_X - bx_s;

  // x*e is 4.(2*WIDTH); keep the 2.WIDTH window, dropping the low fraction bits.
  assign x_next_s = XW'(({{XW{1'b0}}, x_r} * {{XW{1'b0}}, e_r}) >> WIDTH);

  assign ax_full_s  = {{XW{1'b0}}, a_r} * {{WIDTH{1'b0}}, x_r};
  assign sticky_s   = |ax_full_s[WIDTH:0];
  assign out_fire_s = out_valid_r & out_ready;

  // Final quotient: 1.(WIDTH-1) window of a*x, sticky LSB, saturate when a*x >= 2.
  always_comb begin
    q_final_s = {WIDTH{1'b0}};
    if (ax_full_s[PW-1]) begin
      q_final_s = {WIDTH{1'b1}};
    end else begin
      q_final_s = {ax_full_s[2*WIDTH:WIDTH+2], ax_full_s[WIDTH+1] | sticky_s};
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          if (b[WIDTH-1]) begin
            state_n = S_SEED;
          end else begin
            state_n = S_DONE;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SEED:  state_n = S_MUL_B;
      S_MUL_B: state_n = S_MUL_X;
      S_MUL_X: begin
        if (cnt_r == LAST_CNT) begin
          state_n = S_FINAL;
        end else begin
          state_n = S_MUL_B;
        end
      end
      S_FINAL: state_n = S_DONE;
      S_DONE: begin
        if (out_fire_s) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_DONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      x_r         <= {XW{1'b0}};
      e_r         <= {XW{1'b0}};
      cnt_r       <= 3'd0;
      q_r         <= {WIDTH{1'b0}};
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r    <= state_n;
      in_ready_r <= (state_n == S_IDLE);
      busy_r     <= (state_n != S_IDLE);
      // The error path enters DONE straight from IDLE; its result is shown
      // one cycle later so every result follows the accept by at least a cycle.
      out_valid_r <= (state_n == S_DONE) && (state_r != S_IDLE);
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
            if (!b[WIDTH-1]) begin
              q_r   <= {WIDTH{1'b1}};
              err_r <= 1'b1;
            end
          end
        end
        S_SEED: begin
          x_r   <= x_seed_s;
          cnt_r <= 3'd0;
        end
        S_MUL_B: e_r <= e_next_s;
        S_MUL_X: begin
          x_r   <= x_next_s;
          cnt_r <= cnt_r + 3'd1;
        end
        S_FINAL: begin
          q_r   <= q_final_s;
          err_r <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign q         = q_r;
  assign err       = err_r;

endmodule

// File: tb/tb_newton_div_pipe.sv
// Self-checking bench for newton_div_pipe: a WIDTH=24/ITER=3 instance for
// directed table vectors and corner sequences, and a WIDTH=16/ITER=2
// instance for back-to-back random operands against a reference model.
module tb_newton_div_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv24, ir24, ov24, or24, err24, busy24;
  logic [23:0] a24, b24, q24;
  logic        iv16, ir16, ov16, or16, err16, busy16;
  logic [15:0] a16, b16, q16;

  newton_div_pipe #(.WIDTH(24), .ITER(3)) u_dut24 (
    .clk(clk), .rst(rst), .in_valid(iv24), .in_ready(ir24), .a(a24), .b(b24),
    .out_valid(ov24), .out_ready(or24), .q(q24), .err(err24), .busy(busy24)
  );

  newton_div_pipe #(.WIDTH(16), .ITER(2)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .q(q16), .err(err16), .busy(busy16)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] q;
    int          tol;
    bit          err;
    int          lat;
  } vec_t;

  typedef struct {
    longint unsigned q;
    bit              err;
    int              t;
  } exp_t;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp, input longint unsigned tol);
    longint unsigned diff;
    diff = (act >= exp) ? (act - exp) : (exp - act);
    total_cnt++;
    if (diff <= tol) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (tolerance %0d)", name, act, exp, tol);
  endtask

  // Reference divider: seed lookup, Newton steps and final product in plain
  // integer arithmetic on fixed-point values scaled by 2^w.
  function automatic void ref_div(input int w, input int iters,
                                  input longint unsigned av, input longint unsigned bv,
                                  output longint unsigned qv, output bit ev);
    longint unsigned rom [16];
    longint unsigned x, e, bx, p, wmask, xmask;
    rom = '{64'hff, 64'hdf, 64'hc3, 64'haa, 64'h93, 64'h7f, 64'h6d, 64'h5c,
            64'h4d, 64'h3f, 64'h33, 64'h27, 64'h1c, 64'h12, 64'h08, 64'h00};
    wmask = (64'd1 << w) - 64'd1;
    xmask = (64'd1 << (w + 2)) - 64'd1;
    if (((bv >> (w - 1)) & 64'd1) == 64'd0) begin
      qv = wmask;
      ev = 1'b1;
      return;
    end
    ev = 1'b0;
    x = (64'd1 << w) + (rom[int'((bv >> (w - 5)) & 64'd15)] << (w - 8));
    for (int i = 0; i < iters; i++) begin
      bx = ((bv * x) >> w) & xmask;
      e  = ((64'd2 << w) - bx) & xmask;
      x  = ((x * e) >> w) & xmask;
    end
    p = av * x;
    if ((p >> (2 * w)) >= 64'd2) begin
      qv = wmask;
    end else begin
      qv = (p >> (w + 1)) & wmask;
      if ((p & ((64'd1 << (w + 1)) - 64'd1)) != 64'd0) qv = qv | 64'd1;
    end
  endfunction

  // Present operands for one accept edge; a,b are then scrambled (must be ignored).
  task automatic start24(input logic [23:0] av, input logic [23:0] bv);
    a24 = av; b24 = bv; iv24 = 1'b1;
    @(posedge clk); #1;
    iv24 = 1'b0; a24 = ~av; b24 = ~bv;
  endtask

  // Count edges from the accept until out_valid, bounded.
  task automatic wait24(output int lat, output bit busy_bad);
    bit seen = 1'b0;
    lat = 0;
    busy_bad = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (ir24 || !busy24) busy_bad = 1'b1;
      @(posedge clk); #1;
      if (ov24) begin
        seen = 1'b1;
        lat = c;
      end
    end
  endtask

  task automatic run24(input string tag, input logic [23:0] av, input logic [23:0] bv,
                       input logic [23:0] q_exp, input int tol, input bit err_exp,
                       input int lat_exp);
    int lat;
    bit busy_bad;
    check({tag, "_ready_before"}, ir24, 1, 0);
    start24(av, bv);
    wait24(lat, busy_bad);
    check({tag, "_latency"}, lat, lat_exp, 0);
    check({tag, "_q"}, q24, q_exp, tol);
    check({tag, "_err"}, err24, err_exp, 0);
    check({tag, "_busy_while_op"}, busy_bad, 0, 0);
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, ov24, 0, 0);
    check({tag, "_ready_after"}, ir24, 1, 0);
  endtask

  task automatic random16(input int n);
    exp_t            expq [$];
    exp_t            ex;
    longint unsigned qq;
    bit              ee;
    bit              rdy_before;
    int              t = 0, last_acc = -1, n_acc = 0, n_res = 0, bad_cmp = 0;
    or16 = 1'b1;
    a16 = 16'hffff; b16 = 16'h8000; iv16 = 1'b1;
    rdy_before = ir16;
    while (n_res < n && t < n * 8 + 200) begin
      @(posedge clk); #1;
      t++;
      if (busy16 == ir16) bad_cmp++;
      if (rdy_before && iv16) begin
        ref_div(16, 2, a16, b16, qq, ee);
        ex.q = qq; ex.err = ee; ex.t = t;
        expq.push_back(ex);
        if (last_acc >= 0) check("rand16_interval", t - last_acc, 8, 0);
        last_acc = t;
        n_acc++;
        if (n_acc < n) begin
          case (n_acc % 50)
            1:       begin a16 = 16'h0000; b16 = 16'h8000 | 16'($urandom); end
            2:       begin a16 = 16'hffff; b16 = 16'hffff; end
            default: begin a16 = 16'($urandom); b16 = 16'h8000 | 16'($urandom); end
          endcase
        end else begin
          iv16 = 1'b0;
        end
      end
      if (ov16) begin
        if (expq.size() == 0) begin
          check("rand16_spurious_valid", 1, 0, 0);
        end else begin
          ex = expq.pop_front();
          check("rand16_q", q16, ex.q, 0);
          check("rand16_err", err16, ex.err, 0);
          check("rand16_latency", t - ex.t, 6, 0);
        end
        n_res++;
      end
      rdy_before = ir16;
    end
    check("rand16_result_count", n_res, n, 0);
    check("rand16_busy_vs_ready", bad_cmp, 0, 0);
  endtask

  initial begin
    vec_t            tbl [7];
    longint unsigned qq;
    bit              ee, seen, busy_bad;
    int              lat;
    logic [23:0]     ra, rb;

    tbl[0] = '{24'h800000, 24'h800000, 24'h800000, 1, 1'b0, 8};
    tbl[1] = '{24'hc00000, 24'h800000, 24'hc00000, 1, 1'b0, 8};
    tbl[2] = '{24'h800000, 24'hc00000, 24'h555555, 1, 1'b0, 8};
    tbl[3] = '{24'h000000, 24'h800000, 24'h000000, 1, 1'b0, 8};
    tbl[4] = '{24'h7fffff, 24'hffffff, 24'h3fffff, 1, 1'b0, 8};
    tbl[5] = '{24'h123456, 24'h400000, 24'hffffff, 0, 1'b1, 1};
    tbl[6] = '{24'h654321, 24'h000000, 24'hffffff, 0, 1'b1, 1};

    rst = 1'b1;
    iv24 = 1'b0; a24 = 24'h0; b24 = 24'h0; or24 = 1'b1;
    iv16 = 1'b0; a16 = 16'h0; b16 = 16'h0; or16 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", ov24, 0, 0);
    check("reset_q", q24, 0, 0);
    check("reset_err", err24, 0, 0);
    check("reset_in_ready", ir24, 1, 0);
    check("reset_busy", busy24, 0, 0);
    check("reset16_out_valid", ov16, 0, 0);

    for (int i = 0; i < 7; i++) begin
      run24($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].tol,
            tbl[i].err, tbl[i].lat);
    end

    // Backpressure: result must hold for five stalled cycles.
    ref_div(24, 3, 64'h900000, 64'ha00000, qq, ee);
    or24 = 1'b0;
    start24(24'h900000, 24'ha00000);
    wait24(lat, busy_bad);
    check("bp_latency", lat, 8, 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_valid_held", ov24, 1, 0);
      check("bp_q_held", q24, qq, 0);
      check("bp_err_held", err24, 0, 0);
      check("bp_ready_low", ir24, 0, 0);
    end
    or24 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", ov24, 0, 0);
    check("bp_release_ready", ir24, 1, 0);

    // Reset three edges after the accept discards the operation.
    start24(24'h800000, 24'hc00000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_q", q24, 0, 0);
    check("rst_mid_valid", ov24, 0, 0);
    check("rst_mid_ready", ir24, 1, 0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ov24) seen = 1'b1;
    end
    check("rst_mid_no_result", seen, 0, 0);
    run24("after_rst", 24'h800000, 24'hc00000, 24'h555555, 1, 1'b0, 8);

    // Random operands on the 24-bit instance, some with unnormalised divisors.
    for (int i = 0; i < 16; i++) begin
      ra = 24'($urandom);
      rb = 24'h800000 | 24'($urandom);
      if ($urandom_range(0, 3) == 0) rb = rb & 24'h7fffff;
      ref_div(24, 3, ra, rb, qq, ee);
      run24("rand24", ra, rb, 24'(qq), 0, ee, ee ? 1 : 8);
    end

    random16(1000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
